// File: rtl/winograd_pe_acc.sv
// Winograd PE with channel accumulation, F(4,3)/1x1 mode select and back-pressure.
// Four-stage pipeline: multiply, accumulate, AT transform, A transform + output.
module winograd_pe_acc #(
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 12,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 7,
    parameter int OUT_SHIFT  = 4,
    parameter int MAX_CH     = 16,
    parameter int IDX_W      = 9,
    parameter int OD_W       = 8,
    localparam int CH_W      = $clog2(MAX_CH + 1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [5:0][5:0][DATA_W-1:0]     data_tile_i,
    input  logic [5:0][5:0][WEIGHT_W-1:0]   weight_tile_i,
    input  logic                            mode_i,
    input  logic [CH_W-1:0]                 num_ch_i,
    input  logic [IDX_W-1:0]                x_idx_i,
    input  logic [IDX_W-1:0]                y_idx_i,
    input  logic [OD_W-1:0]                 od_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [5:0][5:0][OUT_W-1:0]      out_tile_o,
    output logic [IDX_W-1:0]                out_x_o,
    output logic [IDX_W-1:0]                out_y_o,
    output logic [OD_W-1:0]                 out_od_o
);

    localparam int PW = DATA_W + WEIGHT_W;
    localparam int TW = ACC_W + 8;
    localparam int AT [4][6] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        hi = {2'b00, {(ACC_W-1){1'b1}}};
        lo = {2'b11, {(ACC_W-1){1'b0}}};
        if (v > hi) return hi[ACC_W-1:0];
        if (v < lo) return lo[ACC_W-1:0];
        return v[ACC_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [TW-1:0] v);
        logic signed [TW-1:0] hi;
        logic signed [TW-1:0] lo;
        hi = {{(TW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = {{(TW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (v > hi) return hi[OUT_W-1:0];
        if (v < lo) return lo[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    logic             stall, adv, accept, first, last;
    logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d, n_q, n_in, n_eff;
    logic             mode_q, mode_sel;
    logic [IDX_W-1:0] x_q, y_q, x_sel, y_sel;
    logic [OD_W-1:0]  od_q, od_sel;

    logic                    s1_valid_q, s1_first_q, s1_last_q, s1_mode_q;
    logic [IDX_W-1:0]        s1_x_q, s1_y_q;
    logic [OD_W-1:0]         s1_od_q;
    logic signed [PW-1:0]    prod    [6][6];
    logic signed [ACC_W-1:0] p_d     [6][6];
    logic signed [ACC_W-1:0] s1_p_q  [6][6];

    logic                    s2_valid_q, s2_mode_q;
    logic [IDX_W-1:0]        s2_x_q, s2_y_q;
    logic [OD_W-1:0]         s2_od_q;
    logic signed [ACC_W:0]   sum     [6][6];
    logic signed [ACC_W-1:0] acc_d   [6][6];
    logic signed [ACC_W-1:0] acc_q   [6][6];

    logic                    t_valid_q, t_mode_q;
    logic [IDX_W-1:0]        t_x_q, t_y_q;
    logic [OD_W-1:0]         t_od_q;
    logic signed [TW-1:0]    t_d     [6][6];
    logic signed [TW-1:0]    t_q     [6][6];
    logic signed [TW-1:0]    y       [6][6];

    logic                          out_valid_q;
    logic [5:0][5:0][OUT_W-1:0]    o_d, out_q;
    logic [IDX_W-1:0]              out_x_q, out_y_q;
    logic [OD_W-1:0]               out_od_q;

    // Group parameters come from the first pair; later pairs only supply tiles.
    always_comb begin
        stall    = out_valid_q && !out_ready_i;
        adv      = !stall;
        accept   = in_valid_i && adv;
        first    = (ch_cnt_q == '0);
        n_in     = (num_ch_i == '0) ? CH_W'(1) : num_ch_i;
        n_eff    = first ? n_in : n_q;
        last     = (ch_cnt_q == n_eff - CH_W'(1));
        mode_sel = first ? mode_i : mode_q;
        x_sel    = first ? x_idx_i : x_q;
        y_sel    = first ? y_idx_i : y_q;
        od_sel   = first ? od_i : od_q;
        ch_cnt_d = ch_cnt_q;
        if (accept) ch_cnt_d = last ? '0 : ch_cnt_q + CH_W'(1);
    end

    always_comb begin
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                prod[r][c]  = $signed(data_tile_i[r][c]) * $signed(weight_tile_i[r][c]);
                p_d[r][c]   = ACC_W'(prod[r][c] >>> FRAC_SHIFT);
                sum[r][c]   = $signed({acc_q[r][c][ACC_W-1], acc_q[r][c]})
                            + $signed({s1_p_q[r][c][ACC_W-1], s1_p_q[r][c]});
                acc_d[r][c] = s1_first_q ? s1_p_q[r][c] : sat_acc(sum[r][c]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                t_d[r][c] = s2_mode_q ? TW'(acc_q[r][c]) : '0;
        if (!s2_mode_q) begin
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 6; c++)
                    for (int k = 0; k < 6; k++)
                        t_d[i][c] = t_d[i][c] + TW'(acc_q[k][c]) * TW'(AT[i][k]);
        end
    end

    always_comb begin
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                y[r][c] = t_mode_q ? t_q[r][c] : '0;
        if (!t_mode_q) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    for (int k = 0; k < 6; k++)
                        y[i][j] = y[i][j] + t_q[i][k] * TW'(AT[j][k]);
        end
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                o_d[r][c] = sat_out(y[r][c] >>> OUT_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_cnt_q    <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            od_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_od_q     <= '0;
            s1_p_q      <= '{default: '0};
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            s2_od_q     <= '0;
            acc_q       <= '{default: '0};
            t_valid_q   <= 1'b0;
            t_mode_q    <= 1'b0;
            t_x_q       <= '0;
            t_y_q       <= '0;
            t_od_q      <= '0;
            t_q         <= '{default: '0};
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_od_q    <= '0;
        end else begin
            ch_cnt_q <= ch_cnt_d;
            if (accept && first) begin
                n_q    <= n_in;
                mode_q <= mode_i;
                x_q    <= x_idx_i;
                y_q    <= y_idx_i;
                od_q   <= od_i;
            end
            if (adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_first_q <= first;
                    s1_last_q  <= last;
                    s1_mode_q  <= mode_sel;
                    s1_x_q     <= x_sel;
                    s1_y_q     <= y_sel;
                    s1_od_q    <= od_sel;
                    s1_p_q     <= p_d;
                end
                s2_valid_q <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    acc_q     <= acc_d;
                    s2_mode_q <= s1_mode_q;
                    s2_x_q    <= s1_x_q;
                    s2_y_q    <= s1_y_q;
                    s2_od_q   <= s1_od_q;
                end
                t_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    t_q      <= t_d;
                    t_mode_q <= s2_mode_q;
                    t_x_q    <= s2_x_q;
                    t_y_q    <= s2_y_q;
                    t_od_q   <= s2_od_q;
                end
                out_valid_q <= t_valid_q;
                if (t_valid_q) begin
                    out_q    <= o_d;
                    out_x_q  <= t_x_q;
                    out_y_q  <= t_y_q;
                    out_od_q <= t_od_q;
                end
            end
        end
    end

    always_comb begin
        in_ready_o  = !stall;
        out_valid_o = out_valid_q;
        out_tile_o  = out_q;
        out_x_o     = out_x_q;
        out_y_o     = out_y_q;
        out_od_o    = out_od_q;
    end

endmodule

// File: tb/tb_winograd_pe_acc.sv
// Directed bench for winograd_pe_acc: latency, modes, accumulation,
// saturation, back-pressure and mid-group reset.
module tb_winograd_pe_acc;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [5:0][5:0][15:0]   data_tile_i;
    logic [5:0][5:0][11:0]   weight_tile_i;
    logic                    mode_i;
    logic [4:0]              num_ch_i;
    logic [8:0]              x_idx_i, y_idx_i;
    logic [7:0]              od_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [5:0][5:0][15:0]   out_tile_o;
    logic [8:0]              out_x_o, out_y_o;
    logic [7:0]              out_od_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t1;
    int s [4] = '{5, 0, 10, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    winograd_pe_acc dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .data_tile_i   (data_tile_i),
        .weight_tile_i (weight_tile_i),
        .mode_i        (mode_i),
        .num_ch_i      (num_ch_i),
        .x_idx_i       (x_idx_i),
        .y_idx_i       (y_idx_i),
        .od_i          (od_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_tile_o    (out_tile_o),
        .out_x_o       (out_x_o),
        .out_y_o       (out_y_o),
        .out_od_o      (out_od_o)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_const(input string tag, input int v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c),
                    $signed(out_tile_o[r][c]), v);
    endtask

    task automatic send(input int d, input int w, input bit m, input int n,
                        input int x, input int yy, input int od);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                data_tile_i[r][c]   = 16'(d);
                weight_tile_i[r][c] = 12'(w);
            end
        mode_i     = m;
        num_ch_i   = 5'(n);
        x_idx_i    = 9'(x);
        y_idx_i    = 9'(yy);
        od_i       = 8'(od);
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int k;
        k = 0;
        while (out_valid_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"}, out_valid_o, 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        send(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_tile", $signed(out_tile_o[2][3]), 0);
        chk("rst_od", out_od_o, 0);

        // Mode 1, N=1, p=256 -> 16; latency check
        send(256, 128, 1, 1, 1, 2, 3);
        chk("lat_e0", out_valid_o, 0);
        repeat (2) @(negedge clk);
        chk("lat_e2", out_valid_o, 0);
        @(negedge clk);
        chk("lat_e3", out_valid_o, 1);
        chk_const("m1", 16);
        chk("m1_x", out_x_o, 1);
        chk("m1_y", out_y_o, 2);
        chk("m1_od", out_od_o, 3);
        @(negedge clk);
        chk("m1_drop", out_valid_o, 0);

        // Negative data, arithmetic shifts
        send(-256, 128, 1, 1, 0, 0, 0);
        wait_out("neg");
        chk_const("neg", -16);
        @(negedge clk);

        // num_ch = 0 behaves as one channel
        send(256, 128, 1, 0, 0, 0, 0);
        wait_out("n0");
        chk("n0_00", $signed(out_tile_o[0][0]), 16);
        chk("n0_55", $signed(out_tile_o[5][5]), 16);
        @(negedge clk);

        // Mode 0, p=16: out[i][j] = s[i]*s[j] inside 4x4, 0 outside
        send(128, 16, 0, 1, 4, 5, 6);
        wait_out("m0");
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                chk($sformatf("m0[%0d][%0d]", r, c), $signed(out_tile_o[r][c]),
                    (r < 4 && c < 4) ? s[r] * s[c] : 0);
        chk("m0_od", out_od_o, 6);
        @(negedge clk);

        // Two back-to-back N=3 groups; mid-group fields must be ignored
        send(128, 16, 1, 3, 5, 7, 3);
        send(128, 16, 0, 1, 100, 100, 100);
        send(128, 16, 0, 1, 100, 100, 100);
        send(128, 16, 1, 3, 9, 11, 4);
        send(128, 16, 0, 7, 50, 50, 50);
        send(128, 16, 0, 7, 50, 50, 50);
        wait_out("grpA");
        t1 = cyc;
        chk_const("grpA", 3);
        chk("grpA_x", out_x_o, 5);
        chk("grpA_y", out_y_o, 7);
        chk("grpA_od", out_od_o, 3);
        @(negedge clk);
        wait_out("grpB");
        chk("grpB_gap", cyc - t1, 3);
        chk_const("grpB", 3);
        chk("grpB_x", out_x_o, 9);
        chk("grpB_y", out_y_o, 11);
        chk("grpB_od", out_od_o, 4);
        @(negedge clk);

        // Output saturation in mode 0
        send(32767, 2047, 0, 1, 0, 0, 0);
        wait_out("satp");
        chk("satp_00", $signed(out_tile_o[0][0]), 32767);
        for (int c = 0; c < 6; c++)
            chk($sformatf("satp_row1[%0d]", c), $signed(out_tile_o[1][c]), 0);
        @(negedge clk);
        send(-32768, 2047, 0, 1, 0, 0, 0);
        wait_out("satn");
        chk("satn_00", $signed(out_tile_o[0][0]), -32768);
        @(negedge clk);

        // N=16 mode 1: accumulator stays in range, output saturates
        for (int i = 0; i < 16; i++) send(32767, 2047, 1, 16, 0, 0, 0);
        wait_out("n16");
        chk("n16_00", $signed(out_tile_o[0][0]), 32767);
        chk("n16_54", $signed(out_tile_o[5][4]), 32767);
        @(negedge clk);

        // Accumulator overflow must clamp, not wrap negative
        for (int i = 0; i < 16; i++) send(-32768, -2048, 1, 16, 0, 0, 0);
        wait_out("accsat");
        chk("accsat_00", $signed(out_tile_o[0][0]), 32767);
        @(negedge clk);

        // Back-pressure with four results in flight
        for (int k = 1; k <= 4; k++) send(256 * k, 128, 1, 1, k, k, k);
        out_ready_i = 1'b0;
        #1;
        chk("bp_valid", out_valid_o, 1);
        chk("bp_ready0", in_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", i), in_ready_o, 0);
            chk($sformatf("bp_hold_%0d", i), $signed(out_tile_o[2][3]), 16);
            chk($sformatf("bp_od_%0d", i), out_od_o, 1);
        end
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("bp_q%0d_valid", k), out_valid_o, 1);
            chk($sformatf("bp_q%0d_val", k), $signed(out_tile_o[2][3]), 16 * k);
            chk($sformatf("bp_q%0d_od", k), out_od_o, k);
            @(negedge clk);
        end
        chk("bp_drain", out_valid_o, 0);

        // Reset mid-group, then a fresh single-channel group
        send(256, 128, 1, 4, 0, 0, 0);
        send(256, 128, 1, 4, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mrst_valid", out_valid_o, 0);
        chk("mrst_ready", in_ready_o, 1);
        send(128, 16, 1, 1, 2, 2, 2);
        wait_out("mrst");
        chk_const("mrst", 1);
        chk("mrst_od", out_od_o, 2);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/winograd_pe_acc.md
# winograd_pe_acc

Parametrised Winograd processing element for the systolic array. It succeeds the single-shot PE with three additions: channel accumulation in the Winograd domain across a programmable number of input channels, a run-time mode select between F(4,3) and 1×1 kernels, and valid/ready back-pressure with saturating fixed-point arithmetic. It sits in the PE grid between the input/weight transform units and the output memory writer. Data and weight forwarding to neighbour PEs stays in the array wrapper.

## Interface
Parameters:
- DATA_W, 16, signed width of each transformed data element
- WEIGHT_W, 12, signed width of each transformed weight element
- ACC_W, 24, signed width of each accumulator lane
- OUT_W, 16, signed width of each output element
- FRAC_SHIFT, 7, arithmetic right shift applied to each product
- OUT_SHIFT, 4, arithmetic right shift applied after the output transform
- MAX_CH, 16, maximum channels per accumulation group
- IDX_W, 9, width of the tile x/y indices
- OD_W, 8, width of the output-depth index

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid_i  in  1  data and weight tile pair valid
- in_ready_o  out  1  PE can accept a pair this cycle
- data_tile_i  in  6×6×DATA_W  transformed input tile
- weight_tile_i  in  6×6×WEIGHT_W  transformed weight tile
- mode_i  in  1  0 = F(4,3) with 4×4 output, 1 = 1×1 kernel with 6×6 passthrough
- num_ch_i  in  $clog2(MAX_CH+1)  channels in this group; 0 is treated as 1
- x_idx_i, y_idx_i  in  IDX_W  tile origin
- od_i  in  OD_W  output channel
- out_valid_o  out  1  result tile valid
- out_ready_i  in  1  downstream accepts the result
- out_tile_o  out  6×6×OUT_W  result tile; lanes outside 4×4 are 0 in mode 0
- out_x_o, out_y_o  out  IDX_W  tile origin of the group
- out_od_o  out  OD_W  output channel of the group

## Operation
- Handshake: a pair is accepted when in_valid_i && in_ready_o. Stall = out_valid_o && !out_ready_i. in_ready_o = !stall. All pipeline stages freeze during a stall.
- S1 (multiply): p[r][c] = (d*w) >>> FRAC_SHIFT. The product is computed at full DATA_W+WEIGHT_W precision, then sign-extended to ACC_W. S1 also carries first, last, mode and the indices.
- Channel counter ch_cnt counts 0 … N-1, with N = max(num_ch_i, 1).
  - first = (ch_cnt == 0). On first, N, mode_i, x/y and od are latched. Values presented mid-group are ignored.
  - last = (ch_cnt == N-1). On last, ch_cnt wraps to 0.
- S2 (accumulate): on first, acc = p; otherwise acc = sat_ACC(acc + p). The sum saturates to ±(2^(ACC_W-1)) rather than wrapping. On last, the sum passes to S3.
- S3 (transform, two stages):
  - Mode 0: T = AT·acc, registered; then Y = T·A. AT rows are [1 1 1 1 1 0], [0 1 -1 2 -2 0], [0 1 1 4 4 0], [0 1 -1 8 -8 1]. Intermediates are ACC_W+8 bits.
  - Mode 1: Y = acc, delayed through the same two registers.
- Output: out_tile_o = sat_OUT(Y >>> OUT_SHIFT). It is held stable, together with the indices, while out_valid_o && !out_ready_i.
- A new group may start the cycle after a last pair. Groups are fully pipelined back to back.
- Reset (reset_n low at a rising edge): all valids go to 0, ch_cnt to 0, and accumulators, tiles and indices to 0. Any partial group is discarded. in_ready_o = 1 after reset.

## Timing
- Accept at edge E: S1 registered at E, S2 accumulator at E+1, transform stage 1 at E+2, output register at E+3. out_valid_o is high in the cycle after E+3 when E carried the last pair.
- Throughput is one pair per cycle with no stall. Latency from the last pair to the output is 4 cycles.
- A stall asserted in cycle t lowers in_ready_o in that same cycle, combinationally. No pair is accepted or lost.
- out_valid_o falls on the edge where out_ready_i is high, unless a new result completes on that same edge.

## Test plan
- Mode 1, N=1, all d=256, w=128: p=256, and every out_tile_o lane = 16. out_valid_o is high in the cycle after E+3.
- Mode 0, N=1, all p=16 (d=128, w=16):
  - out[0][0]=25, out[0][2]=50, out[2][2]=100, out[0][3]=5, out[3][3]=1.
  - Row 1 and column 1 are 0; all lanes outside 4×4 are 0.
- Mode 1, N=3, p=16 per channel, two back-to-back groups with different x/y/od: each group outputs 3 in every lane and carries its own first-tile indices. The second group's output appears 3 cycles after the first's.
- Saturation, mode 0, N=1, d=32767, w=2047: out[0][0]=32767 (saturated) and out[1][*]=0. With N=16 in mode 1, the accumulator stays below ACC_W saturation and the output is 32767.
- Back-pressure: hold out_ready_i=0 for 3 cycles while a result is valid. in_ready_o stays 0 and out_tile_o is unchanged. After release, all 4 queued results appear in order with none lost.
- Reset mid-group: assert reset_n=0 after 2 of N=4 pairs, then send a fresh N=1 group of p=16 in mode 1. The output is 1 per lane, with no stale accumulation.
